// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: mode encoding, speed limit, prescaler sizing.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_e;

    localparam logic [1:0] SPEED_MAX = 2'd3;

    // Wide enough to hold the slowest terminal count, CLK_DIV << SPEED_MAX.
    function automatic int presc_width(input int clk_div);
        return $clog2(clk_div * 8);
    endfunction

    // Mode cycle order on each mode-button press.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_COUNT:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_BLINK;
            default:     return MODE_COUNT;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_debounce.sv
// Debounces one raw active-low button and emits a single-cycle pulse on each accepted press.
// Latency: raw edge to press_pulse is 2 + DEB_CYCLES clk cycles; shorter glitches never reach the output.
// Backpressure: none; the pulse is fire-and-forget and release edges produce nothing.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser, then accept a new level after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_pulse <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign pressed     = ~r_level;
    assign press_pulse = r_pulse;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Button-driven LED pattern engine (COUNT/BOUNCE/BLINK, four step rates); LED_PWM_EN adds duty gating.
// Latency: press pulse to mode/speed update 1 cycle; pattern to led 1 cycle (led is registered).
// Backpressure: none; buttons are sampled continuously and the LED bank always accepts.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CLK_DIV    = 5000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode_n,
    input  logic             btn_spd_n,
`ifdef LED_PWM_EN
    input  logic [3:0]       led_duty,
`endif
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       speed_sel
);

    localparam int PW = presc_width(CLK_DIV);

    logic             w_mode_pulse;
    logic             w_spd_pulse;
    logic             w_mode_held;
    logic             w_spd_held;
    logic [1:0]       w_unused_held;

    mode_e            r_mode;
    logic [1:0]       r_speed;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_pat;
    logic             r_dir_up;
    logic [WIDTH-1:0] r_led;

    logic [PW-1:0]    w_term;
    logic             w_tick;
    mode_e            w_mode_nxt;
    logic [WIDTH-1:0] w_pat_init;
    logic [WIDTH-1:0] w_pat_step;
    logic             w_dir_step;
    logic [WIDTH-1:0] w_led_nxt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_mode_n),
        .pressed     (w_mode_held),
        .press_pulse (w_mode_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_spd (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_spd_n),
        .pressed     (w_spd_held),
        .press_pulse (w_spd_pulse)
    );

    // Held levels are not needed by the pattern engine.
    assign w_unused_held = {w_mode_held, w_spd_held};

    // Power-of-two CLK_DIV can make the shifted value wrap to zero; the -1 then still lands on all-ones.
    assign w_term     = (PW'(CLK_DIV) << r_speed) - PW'(1);
    assign w_tick     = (r_presc == w_term);
    assign w_mode_nxt = next_mode(r_mode);

    // Initial pattern of the mode being entered.
    always_comb begin
        w_pat_init = '0;
        case (w_mode_nxt)
            MODE_BOUNCE: w_pat_init = WIDTH'(1);
            MODE_BLINK:  w_pat_init = '1;
            default:     w_pat_init = '0;
        endcase
    end

    // One pattern step for the current mode; the bounce direction flips as an end bit lights up.
    always_comb begin
        w_pat_step = r_pat;
        w_dir_step = r_dir_up;
        case (r_mode)
            MODE_COUNT: w_pat_step = r_pat + WIDTH'(1);
            MODE_BOUNCE: begin
                if (WIDTH > 1) begin
                    if (r_dir_up) begin
                        w_pat_step = r_pat << 1;
                        if (w_pat_step[WIDTH-1]) w_dir_step = 1'b0;
                    end else begin
                        w_pat_step = r_pat >> 1;
                        if (w_pat_step[0]) w_dir_step = 1'b1;
                    end
                end
            end
            MODE_BLINK: w_pat_step = ~r_pat;
            default:    w_pat_step = r_pat;
        endcase
    end

    // Mode/speed state, prescaler and pattern; a mode change overrides a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= MODE_COUNT;
            r_speed  <= '0;
            r_presc  <= '0;
            r_pat    <= '0;
            r_dir_up <= 1'b1;
        end else begin
            if (w_mode_pulse) begin
                r_mode   <= w_mode_nxt;
                r_pat    <= w_pat_init;
                r_dir_up <= 1'b1;
            end else if (w_tick && !w_spd_pulse) begin
                r_pat    <= w_pat_step;
                r_dir_up <= w_dir_step;
            end
            if (w_spd_pulse) begin
                r_speed <= (r_speed == SPEED_MAX) ? 2'd0 : r_speed + 2'd1;
            end
            if (w_mode_pulse || w_spd_pulse || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] r_pwm_cnt;

    // Free-running duty counter; LEDs are on while it is below led_duty.
    always_ff @(posedge clk) begin
        if (rst) r_pwm_cnt <= '0;
        else     r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end

    assign w_led_nxt = r_pat & {WIDTH{r_pwm_cnt < led_duty}};
`else
    assign w_led_nxt = r_pat;
`endif

    // Registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) r_led <= '0;
        else     r_led <= w_led_nxt;
    end

    assign led       = r_led;
    assign mode      = r_mode;
    assign speed_sel = r_speed;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with WIDTH=4, CLK_DIV=2, DEB_CYCLES=4.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode_n = 1'b1;
    logic       btn_spd_n  = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed_sel;
`ifdef LED_PWM_EN
    logic [3:0] led_duty = 4'd0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.WIDTH(4), .CLK_DIV(2), .DEB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode_n (btn_mode_n),
        .btn_spd_n  (btn_spd_n),
`ifdef LED_PWM_EN
        .led_duty   (led_duty),
`endif
        .led        (led),
        .mode       (mode),
        .speed_sel  (speed_sel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for led to differ from its value at call time.
    task automatic wait_led_change(output logic [3:0] val, output int dt);
        logic [3:0] start;
        int i;
        start = led;
        val   = led;
        dt    = -1;
        i     = 0;
        while (dt < 0 && i < 64) begin
            step();
            i++;
            if (led !== start) begin
                val = led;
                dt  = i;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] v;
        logic [3:0] e;
        int dt;
        rst = 1'b1;
        repeat (3) step();
        checks++; if (led !== 4'b0000) begin failures++; $display("FAIL reset_led got=%b exp=0000", led); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (speed_sel !== 2'd0) begin failures++; $display("FAIL reset_speed got=%0d exp=0", speed_sel); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_led_change(v, dt);
            e = 4'(i + 1);
            checks++; if (v !== e) begin failures++; $display("FAIL count_val step=%0d got=%b exp=%b", i, v, e); end
            if (i > 0) begin
                checks++; if (dt !== 2) begin failures++; $display("FAIL count_spacing step=%0d got=%0d exp=2", i, dt); end
            end
        end
    endtask

    task automatic test_debounce();
        int bad;
        btn_mode_n = 1'b0;
        repeat (3) step();
        btn_mode_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (mode !== 2'd0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL glitch_mode got=%0d bad_cycles exp=0", bad); end
        btn_mode_n = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 6) begin
                checks++; if (mode !== 2'd0) begin failures++; $display("FAIL deb_early got=%0d exp=0", mode); end
            end
            if (n == 7) begin
                checks++; if (mode !== 2'd1) begin failures++; $display("FAIL deb_latency got=%0d exp=1", mode); end
            end
            if (n == 8) begin
                checks++; if (led !== 4'b0001) begin failures++; $display("FAIL bounce_entry got=%b exp=0001", led); end
            end
        end
        btn_mode_n = 1'b1;
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq [6] = '{4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic [3:0] v;
        int dt;
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL bounce_first got=%b exp=0010", led); end
        for (int i = 0; i < 6; i++) begin
            wait_led_change(v, dt);
            checks++; if (v !== exp_seq[i]) begin failures++; $display("FAIL bounce_val step=%0d got=%b exp=%b", i, v, exp_seq[i]); end
            checks++; if (dt !== 2) begin failures++; $display("FAIL bounce_spacing step=%0d got=%0d exp=2", i, dt); end
        end
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL single_press_mode got=%0d exp=1", mode); end
    endtask

    task automatic test_blink_wrap();
        logic [3:0] v;
        int dt;
        btn_mode_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 7) begin
                checks++; if (mode !== 2'd2) begin failures++; $display("FAIL blink_mode got=%0d exp=2", mode); end
            end
            if (n == 8) begin
                checks++; if (led !== 4'b1111) begin failures++; $display("FAIL blink_entry got=%b exp=1111", led); end
            end
        end
        btn_mode_n = 1'b1;
        wait_led_change(v, dt);
        checks++; if (v !== 4'b0000) begin failures++; $display("FAIL blink_off got=%b exp=0000", v); end
        checks++; if (dt !== 2) begin failures++; $display("FAIL blink_off_dt got=%0d exp=2", dt); end
        wait_led_change(v, dt);
        checks++; if (v !== 4'b1111) begin failures++; $display("FAIL blink_on got=%b exp=1111", v); end
        checks++; if (dt !== 2) begin failures++; $display("FAIL blink_on_dt got=%0d exp=2", dt); end
        repeat (10) step();
        btn_mode_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 7) begin
                checks++; if (mode !== 2'd0) begin failures++; $display("FAIL wrap_mode got=%0d exp=0", mode); end
            end
            if (n == 8) begin
                checks++; if (led !== 4'b0000) begin failures++; $display("FAIL wrap_led got=%b exp=0000", led); end
            end
        end
        btn_mode_n = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_speed();
        logic [3:0] v;
        int dt;
        logic [1:0] exp_sel;
        int exp_dt;
        for (int k = 1; k <= 4; k++) begin
            exp_sel = 2'(k);
            exp_dt  = 2 << exp_sel;
            btn_spd_n = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                step();
                if (n == 7) begin
                    checks++; if (speed_sel !== exp_sel) begin failures++; $display("FAIL speed_sel press=%0d got=%0d exp=%0d", k, speed_sel, exp_sel); end
                end
            end
            btn_spd_n = 1'b1;
            wait_led_change(v, dt);
            wait_led_change(v, dt);
            checks++; if (dt !== exp_dt) begin failures++; $display("FAIL tick_spacing press=%0d got=%0d exp=%0d", k, dt, exp_dt); end
            repeat (8) step();
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] v;
        int dt;
        btn_mode_n = 1'b0;
        btn_spd_n  = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 7) begin
                checks++; if (mode !== 2'd1) begin failures++; $display("FAIL both_mode got=%0d exp=1", mode); end
                checks++; if (speed_sel !== 2'd1) begin failures++; $display("FAIL both_speed got=%0d exp=1", speed_sel); end
            end
            if (n == 8) begin
                checks++; if (led !== 4'b0001) begin failures++; $display("FAIL both_entry got=%b exp=0001", led); end
            end
        end
        btn_mode_n = 1'b1;
        btn_spd_n  = 1'b1;
        wait_led_change(v, dt);
        checks++; if (v !== 4'b0010) begin failures++; $display("FAIL both_step got=%b exp=0010", v); end
        checks++; if (dt !== 4) begin failures++; $display("FAIL both_presc_restart got=%0d exp=4", dt); end
    endtask

`ifdef LED_PWM_EN
    task automatic press_btn(input bit is_mode);
        if (is_mode) btn_mode_n = 1'b0;
        else         btn_spd_n  = 1'b0;
        repeat (8) step();
        btn_mode_n = 1'b1;
        btn_spd_n  = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_pwm();
        int lit;
        int bad;
        rst = 1'b1;
        led_duty = 4'd4;
        repeat (3) step();
        rst = 1'b0;
        press_btn(1'b1);
        press_btn(1'b1);
        press_btn(1'b0);
        press_btn(1'b0);
        press_btn(1'b0);
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL pwm_setup_mode got=%0d exp=2", mode); end
        checks++; if (speed_sel !== 2'd3) begin failures++; $display("FAIL pwm_setup_speed got=%0d exp=3", speed_sel); end
        lit = 0;
        bad = 0;
        for (int n = 0; n < 64; n++) begin
            step();
            if (led === 4'b1111) lit++;
            else if (led !== 4'b0000) bad++;
        end
        checks++; if (lit !== 8) begin failures++; $display("FAIL pwm_duty4_lit got=%0d exp=8", lit); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL pwm_partial got=%0d exp=0", bad); end
        led_duty = 4'd0;
        repeat (2) step();
        bad = 0;
        for (int n = 0; n < 32; n++) begin
            step();
            if (led !== 4'b0000) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL pwm_duty0 got=%0d lit_cycles exp=0", bad); end
    endtask
`endif

    initial begin
`ifdef LED_PWM_EN
        test_pwm();
`else
        test_reset();
        test_debounce();
        test_bounce();
        test_blink_wrap();
        test_speed();
        test_simultaneous();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
